varredura_matriz: RTL and testbench

VARREDURA_MATRIZ -- requirements
Module: varredura_matriz

---
 rtl/varredura_matriz_pkg.sv | 22 ++
 rtl/varredura_matriz_temporizador.sv | 39 +++
 rtl/varredura_matriz.sv | 126 ++++++++++++
 tb/tb_varredura_matriz.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/varredura_matriz_pkg.sv
// Shared types and sizes for the 5x7 LED matrix scanner.
// Also holds the column polarity helper used by the top level.
package varredura_matriz_pkg;

    localparam int LINHAS   = 5;
    localparam int COLUNAS  = 7;
    localparam int TIMER_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW,
        APAGA
    } estado_t;

    // Maps "1 = lit" pixel data onto the physical column drive level.
    function automatic logic [COLUNAS-1:0] polariza(input logic [COLUNAS-1:0] pixels,
                                                   input logic ativo_baixo);
        return ativo_baixo ? ~pixels : pixels;
    endfunction

endpackage

// File: rtl/varredura_matriz_temporizador.sv
// Loadable down-counter timing the SHOW and APAGA phases.
// done is high in the last counted cycle; done_next predicts it one cycle early.
module temporizador
    import varredura_matriz_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [TIMER_W-1:0] carga,
    output logic               done,
    output logic               done_next
);

    logic [TIMER_W-1:0] count_reg;
    logic [TIMER_W-1:0] count_next;
    logic               done_reg;

    always_comb begin
        count_next = count_reg;
        if (start)
            count_next = carga;
        else if (count_reg != '0)
            count_next = count_reg - TIMER_W'(1);
    end

    assign done_next = (count_next == TIMER_W'(1));
    assign done      = done_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: rtl/varredura_matriz.sv
// Row-scanning driver for a 5x7 LED matrix with per-frame snapshot,
// anti-ghosting blank gaps and a scroll-step pulse every PASSO frames.
module varredura_matriz
    import varredura_matriz_pkg::*;
#(
    parameter int unsigned DWELL          = 1000,
    parameter int unsigned BLANK          = 8,
    parameter int unsigned PASSO          = 4,
    parameter bit          COL_ACTIVE_LOW = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic [COLUNAS-1:0] l1,
    input  logic [COLUNAS-1:0] l2,
    input  logic [COLUNAS-1:0] l3,
    input  logic [COLUNAS-1:0] l4,
    input  logic [COLUNAS-1:0] l5,
    output logic [LINHAS-1:0]  linhas,
    output logic [COLUNAS-1:0] colunas,
    output logic               avanca
);

    localparam logic [COLUNAS-1:0] INATIVO   = COL_ACTIVE_LOW ? '1 : '0;
    localparam logic [2:0]         ULTIMA    = 3'(LINHAS - 1);
    localparam logic [7:0]         PASSO_FIM = 8'(PASSO - 1);

    estado_t                    state_reg;
    logic [2:0]                 row_reg;
    logic [LINHAS*COLUNAS-1:0]  snapshot_reg;
    logic [7:0]                 frame_cnt_reg;
    logic [LINHAS-1:0]          linhas_reg;
    logic [COLUNAS-1:0]         colunas_reg;
    logic                       avanca_reg;

    logic [COLUNAS-1:0]         snap_row [LINHAS];
    logic [2:0]                 row_next;
    logic                       start;
    logic [TIMER_W-1:0]         carga;
    logic                       done;
    logic                       done_next;
    logic                       avanca_next;

    genvar gi;
    generate
        for (gi = 0; gi < LINHAS; gi++) begin : g_rows
            assign snap_row[gi] = snapshot_reg[gi*COLUNAS +: COLUNAS];
        end
    endgenerate

    assign row_next = row_reg + 3'd1;

    // The timer is reloaded on the cycle that leaves a phase, so it is
    // already counting in the first cycle of the following phase.
    assign start = (state_reg == LOAD)
                || (state_reg == SHOW  && done)
                || (state_reg == APAGA && done && row_reg != ULTIMA);
    assign carga = (state_reg == SHOW) ? TIMER_W'(BLANK) : TIMER_W'(DWELL);

    // True when the coming cycle is the final APAGA cycle of the last row.
    assign avanca_next = ((state_reg == SHOW && done) || (state_reg == APAGA && !done))
                      && row_reg == ULTIMA && done_next && frame_cnt_reg == PASSO_FIM;

    temporizador u_temporizador (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .carga     (carga),
        .done      (done),
        .done_next (done_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            snapshot_reg  <= '0;
            frame_cnt_reg <= '0;
            linhas_reg    <= '0;
            colunas_reg   <= INATIVO;
            avanca_reg    <= 1'b0;
        end else begin
            avanca_reg <= avanca_next;
            case (state_reg)
                IDLE: begin
                    if (en)
                        state_reg <= LOAD;
                end
                LOAD: begin
                    state_reg    <= SHOW;
                    row_reg      <= '0;
                    snapshot_reg <= {l5, l4, l3, l2, l1};
                    linhas_reg   <= LINHAS'(1);
                    colunas_reg  <= polariza(l1, COL_ACTIVE_LOW);
                end
                SHOW: begin
                    if (done) begin
                        state_reg   <= APAGA;
                        linhas_reg  <= '0;
                        colunas_reg <= INATIVO;
                    end
                end
                APAGA: begin
                    if (done) begin
                        if (row_reg == ULTIMA) begin
                            frame_cnt_reg <= (frame_cnt_reg == PASSO_FIM) ? 8'd0
                                                                          : frame_cnt_reg + 8'd1;
                            state_reg     <= en ? LOAD : IDLE;
                        end else begin
                            state_reg   <= SHOW;
                            row_reg     <= row_next;
                            linhas_reg  <= LINHAS'(1) << row_next;
                            colunas_reg <= polariza(snap_row[row_next], COL_ACTIVE_LOW);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign linhas  = linhas_reg;
    assign colunas = colunas_reg;
    assign avanca  = avanca_reg;

endmodule

// File: tb/tb_varredura_matriz.sv
// Frame-level checks of varredura_matriz with DWELL=3, BLANK=1, PASSO=2.
// Expected per-cycle outputs are queued by the driver and compared at negedge.
module tb_varredura_matriz;

    localparam int DWELL = 3;
    localparam int BLANK = 1;
    localparam int PASSO = 2;
    localparam logic [6:0] INACT = 7'b1111111;

    logic       CLK;
    logic       RST;
    logic       en;
    logic [6:0] l1, l2, l3, l4, l5;
    logic [4:0] linhas;
    logic [6:0] colunas;
    logic       avanca;

    typedef struct {
        logic [4:0] lin;
        logic [6:0] col;
        logic       av;
    } exp_t;

    typedef struct {
        logic [6:0] l   [5];
        logic [6:0] col [5];
        int         drop_row;
        int         abort_row;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[6];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   fc     = 0;

    varredura_matriz #(
        .DWELL          (DWELL),
        .BLANK          (BLANK),
        .PASSO          (PASSO),
        .COL_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .en      (en),
        .l1      (l1),
        .l2      (l2),
        .l3      (l3),
        .l4      (l4),
        .l5      (l5),
        .linhas  (linhas),
        .colunas (colunas),
        .avanca  (avanca)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        exp_t e;
        bit   bad;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            bad = 1'b0;
            checks++;
            cyc++;
            if (linhas !== e.lin) bad = 1'b1;
            if (colunas !== e.col) bad = 1'b1;
            if (avanca !== e.av) bad = 1'b1;
            if ((linhas & (linhas - 5'd1)) !== 5'd0) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL cyc%0d lin/col/av got %b/%b/%b want %b/%b/%b",
                         cyc, linhas, colunas, avanca, e.lin, e.col, e.av);
            end else begin
                $display("ok   cyc%0d lin/col/av %b/%b/%b", cyc, linhas, colunas, avanca);
            end
        end
    end

    task automatic step(input logic [4:0] lin, input logic [6:0] col, input logic av);
        exp_t e;
        e.lin = lin;
        e.col = col;
        e.av  = av;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_l(input int i, input bit noise);
        logic [6:0] m;
        m = noise ? 7'b1111111 : 7'b0000000;
        l1 = tbl[i].l[0] ^ m;
        l2 = tbl[i].l[1] ^ m;
        l3 = tbl[i].l[2] ^ m;
        l4 = tbl[i].l[3] ^ m;
        l5 = tbl[i].l[4] ^ m;
    endtask

    // One frame: LOAD, then SHOW/APAGA for five rows; optional en drop or reset abort.
    task automatic run_frame(input int i);
        logic av;
        set_l(i, 1'b0);
        step(5'b00000, INACT, 1'b0);
        for (int r = 0; r < 5; r++) begin
            if (r == tbl[i].drop_row) en = 1'b0;
            for (int d = 0; d < DWELL; d++) begin
                step(5'(1 << r), tbl[i].col[r], 1'b0);
                if (r == 0 && d == 0) set_l(i, 1'b1);
                if (r == tbl[i].abort_row && d == 0) begin
                    RST = 1'b1;
                    step(5'b00000, INACT, 1'b0);
                    RST = 1'b0;
                    fc  = 0;
                    return;
                end
            end
            for (int b = 0; b < BLANK; b++) begin
                av = (r == 4 && b == BLANK - 1 && fc == PASSO - 1);
                step(5'b00000, INACT, av);
            end
        end
        fc = (fc + 1) % PASSO;
        if (!en) begin
            repeat (3) step(5'b00000, INACT, 1'b0);
            en = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0].l   = '{7'b1010111, 7'b0000001, 7'b1111111, 7'b0000000, 7'b1100110};
        tbl[0].col = '{7'b0101000, 7'b1111110, 7'b0000000, 7'b1111111, 7'b0011001};
        tbl[0].drop_row = -1; tbl[0].abort_row = -1;
        tbl[1].l   = '{7'b0110011, 7'b1000000, 7'b0011100, 7'b1110001, 7'b0101010};
        tbl[1].col = '{7'b1001100, 7'b0111111, 7'b1100011, 7'b0001110, 7'b1010101};
        tbl[1].drop_row = -1; tbl[1].abort_row = -1;
        tbl[2].l   = '{7'b1111111, 7'b0010100, 7'b1001001, 7'b0100010, 7'b0000111};
        tbl[2].col = '{7'b0000000, 7'b1101011, 7'b0110110, 7'b1011101, 7'b1111000};
        tbl[2].drop_row = 1;  tbl[2].abort_row = -1;
        tbl[3].l   = '{7'b0001000, 7'b0110110, 7'b1011011, 7'b0000001, 7'b1110000};
        tbl[3].col = '{7'b1110111, 7'b1001001, 7'b0100100, 7'b1111110, 7'b0001111};
        tbl[3].drop_row = -1; tbl[3].abort_row = 2;
        tbl[4].l   = '{7'b0011001, 7'b1100011, 7'b0000011, 7'b1010101, 7'b0111110};
        tbl[4].col = '{7'b1100110, 7'b0011100, 7'b1111100, 7'b0101010, 7'b1000001};
        tbl[4].drop_row = -1; tbl[4].abort_row = -1;
        tbl[5].l   = '{7'b1000001, 7'b0100010, 7'b0010100, 7'b0001000, 7'b1111111};
        tbl[5].col = '{7'b0111110, 7'b1011101, 7'b1101011, 7'b1110111, 7'b0000000};
        tbl[5].drop_row = -1; tbl[5].abort_row = -1;

        RST = 1'b1;
        en  = 1'b1;
        l1 = '0; l2 = '0; l3 = '0; l4 = '0; l5 = '0;
        repeat (2) step(5'b00000, INACT, 1'b0);
        RST = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(i);

        @(negedge CLK);
        #1;
        if (errors == 0)
            $display("PASS all %0d checks", checks);
        else
            $display("FAIL %0d errors", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
